// File: rtl/seq_control_if.sv
// rtl/seq_control_if.sv - microword, condition and slice-control bundle for seq_control
interface seq_control_if #(
    parameter int CTR_W = 12
) ();
    logic             hold;
    logic [3:0]       op_in;
    logic [CTR_W-1:0] addr_in;
    logic [2:0]       csel_in;
    logic             cpol_in;
    logic [7:0]       cond;

    logic             s0;
    logic             s1;
    logic             zero;
    logic             cin;
    logic             re;
    logic             fe;
    logic             pup;
    logic [CTR_W-1:0] din;
    logic [CTR_W-1:0] ctr;
    logic [2:0]       depth;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
        output hold, op_in, addr_in, csel_in, cpol_in, cond,
        input  s0, s1, zero, cin, re, fe, pup, din, ctr, depth, stk_ovf, stk_unf
    );

    modport slave (
        input  hold, op_in, addr_in, csel_in, cpol_in, cond,
        output s0, s1, zero, cin, re, fe, pup, din, ctr, depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/seq_control.sv
// rtl/seq_control.sv - next-address control stage for cascaded 4-bit sequencer slices
module seq_control #(
    parameter int CTR_W = 12
) (
    input  logic          clock,
    input  logic          reset_n,
    seq_control_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_CONT = 4'd0,  OP_JMP  = 4'd1,  OP_CJMP = 4'd2,  OP_CJSR = 4'd3,
        OP_CRTN = 4'd4,  OP_LDCT = 4'd5,  OP_RPCT = 4'd6,  OP_JZ   = 4'd7,
        OP_LDAR = 4'd8,  OP_JAR  = 4'd9,  OP_PUSH = 4'd10, OP_POP  = 4'd11,
        OP_WAIT = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        MUX_PC  = 2'b00,
        MUX_AR  = 2'b01,
        MUX_STK = 2'b10,
        MUX_D   = 2'b11
    } mux_t;

    op_t              pipe_op;
    logic [CTR_W-1:0] pipe_addr;
    logic [2:0]       pipe_csel;
    logic             pipe_cpol;
    logic [CTR_W-1:0] ctr;
    logic [2:0]       depth;
    logic             stk_ovf;
    logic             stk_unf;

    mux_t mux;
    logic cond_sel;
    logic c;
    logic zero_c, cin_c, re_c, fe_c, pup_c;

    always_comb begin
        cond_sel = (pipe_csel == 3'd7) ? 1'b1 : bus.cond[pipe_csel];
        c        = cond_sel ^ pipe_cpol;
        mux      = MUX_PC;
        zero_c   = 1'b1;
        cin_c    = 1'b1;
        re_c     = 1'b1;
        fe_c     = 1'b1;
        pup_c    = 1'b0;
        case (pipe_op)
            OP_JMP:  mux = MUX_D;
            OP_CJMP: if (c) mux = MUX_D;
            OP_CJSR: if (c) begin
                mux   = MUX_D;
                fe_c  = 1'b0;
                pup_c = 1'b1;
            end
            OP_CRTN: if (c) begin
                mux  = MUX_STK;
                fe_c = 1'b0;
            end
            OP_RPCT: if (ctr != '0) mux = MUX_D;
            OP_JZ:   zero_c = 1'b0;
            OP_LDAR: re_c = 1'b0;
            OP_JAR:  mux = MUX_AR;
            OP_PUSH: begin
                fe_c  = 1'b0;
                pup_c = 1'b1;
            end
            OP_POP:  fe_c = 1'b0;
            OP_WAIT: if (!c) cin_c = 1'b0;
            default: ;
        endcase
        // Hold makes the slices re-issue the current address; reset outputs win over hold.
        if (bus.hold && reset_n) begin
            mux    = MUX_PC;
            cin_c  = 1'b0;
            fe_c   = 1'b1;
            re_c   = 1'b1;
            zero_c = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_op   <= OP_JZ;
            pipe_addr <= '0;
            pipe_csel <= 3'd7;
            pipe_cpol <= 1'b0;
            ctr       <= '0;
            depth     <= 3'd0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
        end else if (!bus.hold) begin
            pipe_op   <= op_t'(bus.op_in);
            pipe_addr <= bus.addr_in;
            pipe_csel <= bus.csel_in;
            pipe_cpol <= bus.cpol_in;

            if (pipe_op == OP_LDCT)
                ctr <= pipe_addr;
            else if (pipe_op == OP_RPCT && ctr != '0)
                ctr <= ctr - CTR_W'(1);

            // Depth mirrors the slice stack: fe low means the slices push or pop this edge.
            if (!fe_c) begin
                if (pup_c) begin
                    if (depth == 3'd4) stk_ovf <= 1'b1;
                    else               depth   <= depth + 3'd1;
                end else begin
                    if (depth == 3'd0) stk_unf <= 1'b1;
                    else               depth   <= depth - 3'd1;
                end
            end
        end
    end

    assign bus.s1      = mux[1];
    assign bus.s0      = mux[0];
    assign bus.zero    = zero_c;
    assign bus.cin     = cin_c;
    assign bus.re      = re_c;
    assign bus.fe      = fe_c;
    assign bus.pup     = pup_c;
    assign bus.din     = pipe_addr;
    assign bus.ctr     = ctr;
    assign bus.depth   = depth;
    assign bus.stk_ovf = stk_ovf;
    assign bus.stk_unf = stk_unf;
endmodule
